id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe_pkg.sv | 74 +++++++
 rtl/id_ex_pipe_if.sv | 54 +++++
 rtl/id_ex_pipe_hazard_detect.sv | 37 +++
 rtl/id_ex_pipe.sv | 97 +++++++++
 tb/tb_id_ex_pipe.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU and write-back encodings,
// the EX control bundle, and helpers that say which source registers an opcode reads.
package id_ex_pipe_pkg;

    typedef enum logic [6:0] {
        OP_R_TYPE = 7'b0110011,
        OP_I_TYPE = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_LOAD = 2'b00,
        WB_ALU  = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    // Decoder control bundle carried into EX; all-zero is the bubble.
    typedef struct packed {
        logic       rd_wren;
        logic       br_un;
        logic       opa_sel;
        logic       opb_sel;
        logic       lsu_wren;
        logic       insn_vld;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic [2:0] ld_en;
    } ex_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
    } ex_data_t;

    localparam logic [15:0] BUBBLE_CNT_MAX = 16'hFFFF;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        case (opcode)
            OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        case (opcode)
            OP_R_TYPE, OP_STORE, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_pipe_if.sv
// ID-to-EX bus: ID-stage datapath/control values in, registered EX-stage values out.
interface id_ex_pipe_if;

    logic [31:0] i_id_pc;
    logic [31:0] i_id_instr;
    logic [31:0] i_id_rs1_data;
    logic [31:0] i_id_rs2_data;
    logic [31:0] i_id_imm;
    logic        i_rd_wren;
    logic        i_br_un;
    logic        i_opa_sel;
    logic        i_opb_sel;
    logic        i_lsu_wren;
    logic        i_insn_vld;
    logic [3:0]  i_alu_op;
    logic [1:0]  i_wb_sel;
    logic [2:0]  i_ld_en;

    logic [31:0] o_ex_pc;
    logic [31:0] o_ex_instr;
    logic [31:0] o_ex_rs1_data;
    logic [31:0] o_ex_rs2_data;
    logic [31:0] o_ex_imm;
    logic        o_ex_rd_wren;
    logic        o_ex_br_un;
    logic        o_ex_opa_sel;
    logic        o_ex_opb_sel;
    logic        o_ex_lsu_wren;
    logic        o_ex_insn_vld;
    logic [3:0]  o_ex_alu_op;
    logic [1:0]  o_ex_wb_sel;
    logic [2:0]  o_ex_ld_en;

    // Decoder side: drives the ID values, observes the EX register.
    modport master (
        output i_id_pc, i_id_instr, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_rd_wren, i_br_un, i_opa_sel, i_opb_sel, i_lsu_wren, i_insn_vld,
               i_alu_op, i_wb_sel, i_ld_en,
        input  o_ex_pc, o_ex_instr, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
               o_ex_rd_wren, o_ex_br_un, o_ex_opa_sel, o_ex_opb_sel, o_ex_lsu_wren,
               o_ex_insn_vld, o_ex_alu_op, o_ex_wb_sel, o_ex_ld_en
    );

    // Pipeline register side.
    modport slave (
        input  i_id_pc, i_id_instr, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_rd_wren, i_br_un, i_opa_sel, i_opb_sel, i_lsu_wren, i_insn_vld,
               i_alu_op, i_wb_sel, i_ld_en,
        output o_ex_pc, o_ex_instr, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
               o_ex_rd_wren, o_ex_br_un, o_ex_opa_sel, o_ex_opb_sel, o_ex_lsu_wren,
               o_ex_insn_vld, o_ex_alu_op, o_ex_wb_sel, o_ex_ld_en
    );

endinterface

// File: rtl/id_ex_pipe_hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads the register a load in EX
// has not yet produced. A flush discards the ID instruction, so it cannot hazard.
module hazard_detect
    import id_ex_pipe_pkg::*;
(
    input  logic       ex_insn_vld,
    input  logic       ex_rd_wren,
    input  logic [1:0] ex_wb_sel,
    input  logic [4:0] ex_rd,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_insn_vld,
    input  logic       flush,
    output logic       hzd_stall
);

    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;

    // Compare ID source registers against the destination of a load in EX.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ex_is_load = 1'b0;
        rs1_match  = 1'b0;
        rs2_match  = 1'b0;
        hzd_stall  = 1'b0;

        ex_is_load = ex_insn_vld && ex_rd_wren && (ex_wb_sel == WB_LOAD);
        rs1_match  = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
        rs2_match  = uses_rs2(id_opcode) && (id_rs2 == ex_rd);
        hzd_stall  = !flush && ex_is_load && (ex_rd != 5'd0) && id_insn_vld
                     && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush, stall and load-use bubble insertion,
// plus a saturating count of inserted bubbles.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_stall,
    input  logic         i_flush,
    id_ex_pipe_if.slave  bus,
    output logic         o_hzd_stall,
    output logic [15:0]  o_bubble_cnt
);

    ex_ctrl_t id_ctrl;
    ex_data_t id_data;
    ex_ctrl_t ex_ctrl_q;
    ex_data_t ex_data_q;
    logic     load_bubble;

    assign id_ctrl = '{
        rd_wren:  bus.i_rd_wren,
        br_un:    bus.i_br_un,
        opa_sel:  bus.i_opa_sel,
        opb_sel:  bus.i_opb_sel,
        lsu_wren: bus.i_lsu_wren,
        insn_vld: bus.i_insn_vld,
        alu_op:   bus.i_alu_op,
        wb_sel:   bus.i_wb_sel,
        ld_en:    bus.i_ld_en
    };

    assign id_data = '{
        pc:       bus.i_id_pc,
        instr:    bus.i_id_instr,
        rs1_data: bus.i_id_rs1_data,
        rs2_data: bus.i_id_rs2_data,
        imm:      bus.i_id_imm
    };

    hazard_detect u_hazard_detect (
        .ex_insn_vld (ex_ctrl_q.insn_vld),
        .ex_rd_wren  (ex_ctrl_q.rd_wren),
        .ex_wb_sel   (ex_ctrl_q.wb_sel),
        .ex_rd       (ex_data_q.instr[11:7]),
        .id_opcode   (bus.i_id_instr[6:0]),
        .id_rs1      (bus.i_id_instr[19:15]),
        .id_rs2      (bus.i_id_instr[24:20]),
        .id_insn_vld (bus.i_insn_vld),
        .flush       (i_flush),
        .hzd_stall   (o_hzd_stall)
    );

    // Flush beats stall; a hazard only inserts a bubble when EX is free to advance.
    assign load_bubble = i_flush || (!i_stall && o_hzd_stall);

    // EX register: bubble on flush/hazard, hold on stall, otherwise capture ID.
    always_ff @(posedge i_clk or posedge i_reset) begin
        // NOTE: reset clears every EX field to the bubble; these are flops, not a memory, so all are reset.
        if (i_reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            ex_ctrl_q <= '0;
            ex_data_q <= '0;
        end else if (load_bubble) begin
            ex_ctrl_q <= '0;
            ex_data_q <= '0;
        end else if (!i_stall) begin
            ex_ctrl_q <= id_ctrl;
            ex_data_q <= id_data;
        end
    end

    // Bubble counter: one per inserted bubble, sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_bubble_cnt <= 16'd0;
        end else if (load_bubble && (o_bubble_cnt != BUBBLE_CNT_MAX)) begin
            o_bubble_cnt <= o_bubble_cnt + 16'd1;
        end
    end

    assign bus.o_ex_pc       = ex_data_q.pc;
    assign bus.o_ex_instr    = ex_data_q.instr;
    assign bus.o_ex_rs1_data = ex_data_q.rs1_data;
    assign bus.o_ex_rs2_data = ex_data_q.rs2_data;
    assign bus.o_ex_imm      = ex_data_q.imm;
    assign bus.o_ex_rd_wren  = ex_ctrl_q.rd_wren;
    assign bus.o_ex_br_un    = ex_ctrl_q.br_un;
    assign bus.o_ex_opa_sel  = ex_ctrl_q.opa_sel;
    assign bus.o_ex_opb_sel  = ex_ctrl_q.opb_sel;
    assign bus.o_ex_lsu_wren = ex_ctrl_q.lsu_wren;
    assign bus.o_ex_insn_vld = ex_ctrl_q.insn_vld;
    assign bus.o_ex_alu_op   = ex_ctrl_q.alu_op;
    assign bus.o_ex_wb_sel   = ex_ctrl_q.wb_sel;
    assign bus.o_ex_ld_en    = ex_ctrl_q.ld_en;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: capture, load-use bubbles, flush/stall priority,
// saturation of the bubble counter and asynchronous reset.
module tb_id_ex_pipe;

    // Hand-assembled instructions
    localparam logic [31:0] I_ADD_3_1_2  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_LW_5_0_1   = 32'h0000A283; // lw  x5,0(x1)
    localparam logic [31:0] I_LW_0_0_1   = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] I_ADD_6_5_2  = 32'h00228333; // add x6,x5,x2
    localparam logic [31:0] I_ADD_7_1_5  = 32'h005083B3; // add x7,x1,x5
    localparam logic [31:0] I_ADD_6_0_0  = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] I_LUI_5      = 32'h000282B7; // lui x5,0x28 (rs1 field = 5)

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        hzd_stall;
    logic [15:0] bubble_cnt;
    int          errors;
    int          checks;
    logic [15:0] exp_cnt;

    id_ex_pipe_if bus ();

    id_ex_pipe dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_stall      (stall),
        .i_flush      (flush),
        .bus          (bus.slave),
        .o_hzd_stall  (hzd_stall),
        .o_bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one ID instruction; unlisted control bits are zero.
    task automatic drive_id(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] rs1d, input logic [31:0] rs2d,
                            input logic [31:0] imm, input logic rd_wren,
                            input logic opb_sel, input logic vld,
                            input logic [3:0] alu, input logic [1:0] wb,
                            input logic [2:0] ld);
        bus.i_id_pc       = pc;
        bus.i_id_instr    = instr;
        bus.i_id_rs1_data = rs1d;
        bus.i_id_rs2_data = rs2d;
        bus.i_id_imm      = imm;
        bus.i_rd_wren     = rd_wren;
        bus.i_br_un       = 1'b0;
        bus.i_opa_sel     = 1'b0;
        bus.i_opb_sel     = opb_sel;
        bus.i_lsu_wren    = 1'b0;
        bus.i_insn_vld    = vld;
        bus.i_alu_op      = alu;
        bus.i_wb_sel      = wb;
        bus.i_ld_en       = ld;
    endtask

    task automatic drive_add(input logic [31:0] pc, input logic [31:0] instr);
        drive_id(pc, instr, 32'h1111_0001, 32'h2222_0002, 32'h0, 1'b1, 1'b0, 1'b1,
                 4'b0000, 2'b01, 3'b000);
    endtask

    task automatic drive_lw(input logic [31:0] pc, input logic [31:0] instr);
        drive_id(pc, instr, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1,
                 4'b0000, 2'b00, 3'b010);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_add(32'h0, I_ADD_6_5_2);
        #1;
        checks++; if (bus.o_ex_insn_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0h want 0", bus.o_ex_insn_vld); end
        checks++; if (bus.o_ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h want 0", bus.o_ex_pc); end
        checks++; if (bus.o_ex_rd_wren !== 1'b0) begin errors++; $display("FAIL reset_rd_wren: got %0h want 0", bus.o_ex_rd_wren); end
        checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %0h want 0", bubble_cnt); end
        tick();
        checks++; if (hzd_stall !== 1'b0) begin errors++; $display("FAIL reset_hzd: got %0h want 0", hzd_stall); end
        checks++; if (bus.o_ex_instr !== 32'h0) begin errors++; $display("FAIL reset_hold_instr: got %0h want 0", bus.o_ex_instr); end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'h0;
    endtask

    task automatic test_capture();
        drive_add(32'h10, I_ADD_3_1_2);
        tick();
        checks++; if (bus.o_ex_pc !== 32'h10) begin errors++; $display("FAIL cap_pc: got %0h want 10", bus.o_ex_pc); end
        checks++; if (bus.o_ex_instr !== I_ADD_3_1_2) begin errors++; $display("FAIL cap_instr: got %0h want %0h", bus.o_ex_instr, I_ADD_3_1_2); end
        checks++; if (bus.o_ex_alu_op !== 4'b0000) begin errors++; $display("FAIL cap_alu_op: got %0h want 0", bus.o_ex_alu_op); end
        checks++; if (bus.o_ex_wb_sel !== 2'b01) begin errors++; $display("FAIL cap_wb_sel: got %0h want 1", bus.o_ex_wb_sel); end
        checks++; if (bus.o_ex_rd_wren !== 1'b1) begin errors++; $display("FAIL cap_rd_wren: got %0h want 1", bus.o_ex_rd_wren); end
        checks++; if (bus.o_ex_rs1_data !== 32'h1111_0001) begin errors++; $display("FAIL cap_rs1: got %0h want 11110001", bus.o_ex_rs1_data); end
        checks++; if (bus.o_ex_insn_vld !== 1'b1) begin errors++; $display("FAIL cap_vld: got %0h want 1", bus.o_ex_insn_vld); end
    endtask

    task automatic test_load_use();
        // rs1 hazard
        drive_lw(32'h14, I_LW_5_0_1);
        tick();
        drive_add(32'h18, I_ADD_6_5_2);
        #1;
        checks++; if (hzd_stall !== 1'b1) begin errors++; $display("FAIL lu_rs1_hzd: got %0h want 1", hzd_stall); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus.o_ex_insn_vld !== 1'b0) begin errors++; $display("FAIL lu_bubble_vld: got %0h want 0", bus.o_ex_insn_vld); end
        checks++; if (bus.o_ex_rd_wren !== 1'b0 || bus.o_ex_lsu_wren !== 1'b0) begin errors++; $display("FAIL lu_bubble_wren: got %0h/%0h want 0/0", bus.o_ex_rd_wren, bus.o_ex_lsu_wren); end
        checks++; if (bus.o_ex_pc !== 32'h0 || bus.o_ex_instr !== 32'h0) begin errors++; $display("FAIL lu_bubble_data: got %0h/%0h want 0/0", bus.o_ex_pc, bus.o_ex_instr); end
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0h want 1", bubble_cnt); end
        checks++; if (hzd_stall !== 1'b0) begin errors++; $display("FAIL lu_hzd_clear: got %0h want 0", hzd_stall); end
        tick();
        checks++; if (bus.o_ex_pc !== 32'h18 || bus.o_ex_instr !== I_ADD_6_5_2) begin errors++; $display("FAIL lu_resume: got %0h/%0h want 18/%0h", bus.o_ex_pc, bus.o_ex_instr, I_ADD_6_5_2); end
        // rs2 hazard
        drive_lw(32'h1C, I_LW_5_0_1);
        tick();
        drive_add(32'h20, I_ADD_7_1_5);
        #1;
        checks++; if (hzd_stall !== 1'b1) begin errors++; $display("FAIL lu_rs2_hzd: got %0h want 1", hzd_stall); end
        // ID not valid: no hazard
        bus.i_insn_vld = 1'b0;
        #1;
        checks++; if (hzd_stall !== 1'b0) begin errors++; $display("FAIL lu_id_invalid: got %0h want 0", hzd_stall); end
        bus.i_insn_vld = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bubble_cnt !== exp_cnt) begin errors++; $display("FAIL lu_rs2_cnt: got %0h want %0h", bubble_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_no_hazard();
        drive_lw(32'h30, I_LW_0_0_1);
        tick();
        drive_add(32'h34, I_ADD_6_0_0);
        #1;
        checks++; if (hzd_stall !== 1'b0) begin errors++; $display("FAIL nh_x0: got %0h want 0", hzd_stall); end
        drive_lw(32'h38, I_LW_5_0_1);
        tick();
        drive_id(32'h3C, I_LUI_5, 32'h0, 32'h0, 32'h0002_8000, 1'b1, 1'b1, 1'b1,
                 4'b1010, 2'b01, 3'b000);
        #1;
        checks++; if (hzd_stall !== 1'b0) begin errors++; $display("FAIL nh_lui: got %0h want 0", hzd_stall); end
        tick();
        checks++; if (bus.o_ex_pc !== 32'h3C || bubble_cnt !== exp_cnt) begin errors++; $display("FAIL nh_capture: got %0h/%0h want 3c/%0h", bus.o_ex_pc, bubble_cnt, exp_cnt); end
    endtask

    task automatic test_flush_stall();
        drive_lw(32'h40, I_LW_5_0_1);
        tick();
        drive_add(32'h44, I_ADD_6_5_2);
        stall = 1'b1;
        #1;
        checks++; if (hzd_stall !== 1'b1) begin errors++; $display("FAIL fs_hzd_stall: got %0h want 1", hzd_stall); end
        tick();
        checks++; if (bus.o_ex_pc !== 32'h40 || bus.o_ex_instr !== I_LW_5_0_1) begin errors++; $display("FAIL fs_hold_load: got %0h/%0h want 40/%0h", bus.o_ex_pc, bus.o_ex_instr, I_LW_5_0_1); end
        checks++; if (hzd_stall !== 1'b1 || bubble_cnt !== exp_cnt) begin errors++; $display("FAIL fs_hold_hzd: got %0h/%0h want 1/%0h", hzd_stall, bubble_cnt, exp_cnt); end
        flush = 1'b1;
        #1;
        checks++; if (hzd_stall !== 1'b0) begin errors++; $display("FAIL fs_flush_hzd: got %0h want 0", hzd_stall); end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus.o_ex_insn_vld !== 1'b0 || bus.o_ex_pc !== 32'h0) begin errors++; $display("FAIL fs_bubble: got %0h/%0h want 0/0", bus.o_ex_insn_vld, bus.o_ex_pc); end
        checks++; if (bubble_cnt !== exp_cnt) begin errors++; $display("FAIL fs_cnt: got %0h want %0h", bubble_cnt, exp_cnt); end
        flush = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_stall_hold();
        drive_add(32'h50, I_ADD_3_1_2);
        tick();
        stall = 1'b1;
        drive_lw(32'h99, I_LW_5_0_1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.o_ex_pc !== 32'h50 || bus.o_ex_instr !== I_ADD_3_1_2 ||
                bus.o_ex_rs1_data !== 32'h1111_0001 || bus.o_ex_wb_sel !== 2'b01 ||
                bus.o_ex_opb_sel !== 1'b0 || bubble_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL stall_hold_%0d: got pc=%0h instr=%0h cnt=%0h want pc=50 instr=%0h cnt=%0h",
                         i, bus.o_ex_pc, bus.o_ex_instr, bubble_cnt, I_ADD_3_1_2, exp_cnt);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_cnt = 16'h0;
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (bubble_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %0h want fffe", bubble_cnt); end
        tick();
        checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max: got %0h want ffff", bubble_cnt); end
        tick();
        checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h want ffff", bubble_cnt); end
        flush = 1'b0;
        exp_cnt = 16'hFFFF;
    endtask

    task automatic test_reset_mid();
        drive_add(32'h60, I_ADD_3_1_2);
        tick();
        checks++; if (bus.o_ex_insn_vld !== 1'b1) begin errors++; $display("FAIL rm_pre_vld: got %0h want 1", bus.o_ex_insn_vld); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.o_ex_insn_vld !== 1'b0 || bus.o_ex_pc !== 32'h0) begin errors++; $display("FAIL rm_async_ex: got %0h/%0h want 0/0", bus.o_ex_insn_vld, bus.o_ex_pc); end
        checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL rm_async_cnt: got %0h want 0", bubble_cnt); end
        #1;
        rst = 1'b0;
        drive_add(32'h64, I_ADD_3_1_2);
        tick();
        checks++; if (bus.o_ex_pc !== 32'h64 || bus.o_ex_insn_vld !== 1'b1 || bubble_cnt !== 16'h0) begin errors++; $display("FAIL rm_after: got %0h/%0h/%0h want 64/1/0", bus.o_ex_pc, bus.o_ex_insn_vld, bubble_cnt); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        exp_cnt = 16'h0;
        test_reset();
        test_capture();
        test_load_use();
        test_no_hazard();
        test_flush_stall();
        test_stall_hold();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
